// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two write ports, a scoreboard issue port and NRD packed read ports.
interface regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 2
);
    logic                  write0;
    logic [ADDR_W-1:0]     waddr0;
    logic [WIDTH-1:0]      in0;
    logic                  write1;
    logic [ADDR_W-1:0]     waddr1;
    logic [WIDTH-1:0]      in1;
    logic                  issue;
    logic [ADDR_W-1:0]     issue_addr;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*WIDTH-1:0]  out;
    logic [NRD-1:0]        rbusy;
    logic                  busy_any;

    modport master (
        output write0, waddr0, in0, write1, waddr1, in1, issue, issue_addr, raddr,
        input  out, rbusy, busy_any
    );

    modport slave (
        input  write0, waddr0, in0, write1, waddr1, in1, issue, issue_addr, raddr,
        output out, rbusy, busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads are combinational and optionally forward same-cycle write data.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pendNext;
    logic             keep0;
    logic             keep1;
    logic             keepIssue;

    // With a hardwired zero register, anything aimed at address 0 is ignored.
    assign keep0     = bus.write0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign keep1     = bus.write1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign keepIssue = bus.issue  && !((ZERO_REG != 0) && (bus.issue_addr == '0));

    // Issue is applied after the clears so a newer pending write survives its predecessor's commit.
    always_comb begin
        pendNext = pend;
        if (bus.write0) pendNext[bus.waddr0] = 1'b0;
        if (bus.write1) pendNext[bus.waddr1] = 1'b0;
        if (keepIssue)  pendNext[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend <= '0;
        end else begin
            if (keep0) regs[bus.waddr0] <= bus.in0;
            if (keep1) regs[bus.waddr1] <= bus.in1;
            pend <= pendNext;
        end
    end

    assign bus.busy_any = |pend;

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic              isZero;
        logic              hit0;
        logic              hit1;
        logic              issueHit;

        assign ra       = bus.raddr[k*ADDR_W +: ADDR_W];
        assign isZero   = (ZERO_REG != 0) && (ra == '0);
        // Forwarding is held off during reset so outputs stay zero regardless of the write ports.
        assign hit1     = (BYPASS != 0) && rst_n && bus.write1 && (bus.waddr1 == ra);
        assign hit0     = (BYPASS != 0) && rst_n && bus.write0 && (bus.waddr0 == ra);
        assign issueHit = bus.issue && (bus.issue_addr == ra);

        assign bus.out[k*WIDTH +: WIDTH] = isZero ? '0 :
                                           hit1   ? bus.in1 :
                                           hit0   ? bus.in0 : regs[ra];
        assign bus.rbusy[k] = isZero        ? 1'b0 :
                              (hit1 || hit0) ? issueHit : pend[ra];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing instance and a non-bypassing zero-register
// instance share one stimulus stream and are checked against an array model every cycle.
module tb_regfile_sb;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;
    localparam int NRD    = 2;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              w0 = 0, w1 = 0, iss = 0;
    logic [ADDR_W-1:0] a0 = 0, a1 = 0, ia = 0;
    logic [WIDTH-1:0]  d0 = 0, d1 = 0;
    logic [NRD*ADDR_W-1:0] raddr = 0;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    regfile_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD)) ifA ();
    regfile_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD)) ifB ();

    assign ifA.write0 = w0;  assign ifB.write0 = w0;
    assign ifA.waddr0 = a0;  assign ifB.waddr0 = a0;
    assign ifA.in0 = d0;     assign ifB.in0 = d0;
    assign ifA.write1 = w1;  assign ifB.write1 = w1;
    assign ifA.waddr1 = a1;  assign ifB.waddr1 = a1;
    assign ifA.in1 = d1;     assign ifB.in1 = d1;
    assign ifA.issue = iss;  assign ifB.issue = iss;
    assign ifA.issue_addr = ia; assign ifB.issue_addr = ia;
    assign ifA.raddr = raddr;   assign ifB.raddr = raddr;

    regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(1), .ZERO_REG(0)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(ifA)
    );
    regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB)
    );

    // Model state per instance: index 0 = bypass/no zero reg, index 1 = no bypass/zero reg.
    logic [WIDTH-1:0] mRegs [2][DEPTH];
    bit               mPend [2][DEPTH];
    bit               cfgBypass [2] = '{1'b1, 1'b0};
    bit               cfgZero   [2] = '{1'b0, 1'b1};

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < DEPTH; i++) begin
                mRegs[c][i] = '0;
                mPend[c][i] = 1'b0;
            end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mRegs[c][i] = '0;
                    mPend[c][i] = 1'b0;
                end
            end else begin
                if (w0 && !(cfgZero[c] && a0 == 0)) mRegs[c][a0] = d0;
                if (w1 && !(cfgZero[c] && a1 == 0)) mRegs[c][a1] = d1;
                if (w0) mPend[c][a0] = 1'b0;
                if (w1) mPend[c][a1] = 1'b0;
                if (iss && !(cfgZero[c] && ia == 0)) mPend[c][ia] = 1'b1;
            end
        end
    end

    function automatic logic [WIDTH-1:0] expData(int c, logic [ADDR_W-1:0] a);
        if (!rst_n) return '0;
        if (cfgZero[c] && a == 0) return '0;
        if (cfgBypass[c] && w1 && a1 == a) return d1;
        if (cfgBypass[c] && w0 && a0 == a) return d0;
        return mRegs[c][a];
    endfunction

    function automatic logic expBusy(int c, logic [ADDR_W-1:0] a);
        if (!rst_n) return 1'b0;
        if (cfgZero[c] && a == 0) return 1'b0;
        if (cfgBypass[c] && ((w1 && a1 == a) || (w0 && a0 == a))) return iss && ia == a;
        return mPend[c][a];
    endfunction

    function automatic logic expAny(int c);
        logic any = 1'b0;
        for (int i = 0; i < DEPTH; i++) any |= mPend[c][i];
        return any;
    endfunction

    task automatic checkOutput(string name, logic [WIDTH-1:0] actual, logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < NRD; k++) begin
                logic [ADDR_W-1:0] a;
                a = raddr[k*ADDR_W +: ADDR_W];
                checkOutput($sformatf("A.out%0d", k), ifA.out[k*WIDTH +: WIDTH], expData(0, a));
                checkOutput($sformatf("B.out%0d", k), ifB.out[k*WIDTH +: WIDTH], expData(1, a));
                checkOutput($sformatf("A.rbusy%0d", k), 32'(ifA.rbusy[k]), 32'(expBusy(0, a)));
                checkOutput($sformatf("B.rbusy%0d", k), 32'(ifB.rbusy[k]), 32'(expBusy(1, a)));
            end
            checkOutput("A.busy_any", 32'(ifA.busy_any), 32'(expAny(0)));
            checkOutput("B.busy_any", 32'(ifB.busy_any), 32'(expAny(1)));
        end
    end

    task automatic applyStimulus(input logic wr0, input logic [3:0] ad0, input logic [31:0] dt0,
                                 input logic wr1, input logic [3:0] ad1, input logic [31:0] dt1,
                                 input logic is, input logic [3:0] isa,
                                 input logic [3:0] r0, input logic [3:0] r1);
        w0 = wr0; a0 = ad0; d0 = dt0;
        w1 = wr1; a1 = ad1; d1 = dt1;
        iss = is; ia = isa;
        raddr = {r1, r0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] randAddr();
        logic [3:0] a;
        a = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a & 4'h7;
        return a;
    endfunction

    initial begin
        #1;
        checkEn = 1;
        nextCycle();
        #2;
        checkOutput("reset.out", ifA.out[31:0], 32'h0);
        rst_n = 1'b1;
        nextCycle();

        // Fill r1..r5 and leave r9 pending, then reset between edges.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 4'(i), 32'h100 + 32'(i), 0, 0, 0, (i == 1), 4'd9, 0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd1, 4'd5);
        #2;
        checkOutput("fill.r1", ifA.out[31:0], 32'h101);
        checkOutput("fill.r5", ifB.out[63:32], 32'h105);
        checkOutput("fill.busy_any", 32'(ifA.busy_any), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.A.out0", ifA.out[31:0], 32'h0);
        checkOutput("rst.B.out1", ifB.out[63:32], 32'h0);
        checkOutput("rst.busy_any", 32'(ifA.busy_any), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Same-address write conflict: port 1 wins.
        applyStimulus(1, 4'd3, 32'h11, 1, 4'd3, 32'h22, 0, 0, 4'd3, 4'd3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd3);
        #2;
        checkOutput("conflict.A", ifA.out[31:0], 32'h22);
        checkOutput("conflict.B", ifB.out[63:32], 32'h22);

        // Bypass versus registered read.
        applyStimulus(1, 4'd7, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 4'd7, 32'hAB, 0, 0, 0, 0, 0, 4'd7, 0);
        #2;
        checkOutput("bypass.A", ifA.out[31:0], 32'hAB);
        checkOutput("nobypass.B", ifB.out[31:0], 32'h55);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd7, 0);
        #2;
        checkOutput("nobypass.B.next", ifB.out[31:0], 32'hAB);

        // Scoreboard set then clear.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd4, 4'd4, 0);
        #2;
        checkOutput("sb.issue.rbusy", 32'(ifA.rbusy[0]), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd4, 0);
        #2;
        checkOutput("sb.A.rbusy", 32'(ifA.rbusy[0]), 32'h1);
        checkOutput("sb.A.busy_any", 32'(ifA.busy_any), 32'h1);
        checkOutput("sb.B.rbusy", 32'(ifB.rbusy[0]), 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 4'd4, 32'h44, 0, 0, 4'd4, 0);
        #2;
        checkOutput("sb.wb.A.rbusy", 32'(ifA.rbusy[0]), 32'h0);
        checkOutput("sb.wb.B.rbusy", 32'(ifB.rbusy[0]), 32'h1);
        checkOutput("sb.wb.A.out", ifA.out[31:0], 32'h44);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd4, 0);
        #2;
        checkOutput("sb.clr.A.busy_any", 32'(ifA.busy_any), 32'h0);
        checkOutput("sb.clr.B.busy_any", 32'(ifB.busy_any), 32'h0);

        // Set/clear race on r2: pending stays set, data updates.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd2, 0);
        nextCycle();
        applyStimulus(1, 4'd2, 32'h77, 0, 0, 0, 1, 4'd2, 4'd2, 0);
        #2;
        checkOutput("race.A.rbusy", 32'(ifA.rbusy[0]), 32'h1);
        checkOutput("race.B.rbusy", 32'(ifB.rbusy[0]), 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 0);
        #2;
        checkOutput("race.A.pend", 32'(ifA.rbusy[0]), 32'h1);
        checkOutput("race.B.data", ifB.out[31:0], 32'h77);
        applyStimulus(1, 4'd2, 32'h0, 0, 0, 0, 0, 0, 4'd2, 0);
        nextCycle();

        // Zero register on instance B.
        applyStimulus(1, 4'd0, 32'hFF, 0, 0, 0, 1, 4'd0, 4'd0, 0);
        #2;
        checkOutput("zero.B.out", ifB.out[31:0], 32'h0);
        checkOutput("zero.B.rbusy", 32'(ifB.rbusy[0]), 32'h0);
        checkOutput("zero.A.rbusy", 32'(ifA.rbusy[0]), 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
        #2;
        checkOutput("zero.B.after", ifB.out[31:0], 32'h0);
        checkOutput("zero.B.busy_any", 32'(ifB.busy_any), 32'h0);
        checkOutput("zero.A.after", ifA.out[31:0], 32'hFF);
        applyStimulus(1, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 2) == 0), randAddr(), $urandom(),
                          ($urandom_range(0, 2) == 0), randAddr(), $urandom(),
                          ($urandom_range(0, 2) == 0), randAddr(),
                          randAddr(), randAddr());
            rst_n = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
            end
            nextCycle();
        end
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        #1;
        checkEn = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
